// File: rtl/center_pkg.sv
// center_pkg
// Shared constants and the accumulator FSM state type for the centroid
// weight-accumulation slice.
//   NPTS     : points accumulated per job
//   COORD_W  : coordinate width
//   WGT_W    : weight width
//   SUMXY_W  : width of the x*w and y*w accumulators
//   SUMW_W   : width of the weight accumulator
//   state_t  : IDLE (waiting for start), ACC (one point per edge), DONE (result held)
package center_pkg;

   localparam int NPTS    = 6;
   localparam int COORD_W = 8;
   localparam int WGT_W   = 4;
   localparam int SUMXY_W = 15;
   localparam int SUMW_W  = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/point_mac.sv
// point_mac
// Single multiply-accumulate step: sum = acc + coord * weight.
// The product is kept at full precision (COORD_W+WGT_W bits) and then
// zero-extended to the accumulator width before the add.
//   coord  : unsigned coordinate of the current point
//   weight : unsigned weight of the current point
//   acc    : running accumulator value
//   sum    : acc plus this point's weighted coordinate
module point_mac #(
   parameter int COORD_W = 8,
   parameter int WGT_W   = 4,
   parameter int ACC_W   = 15
) (
   input  logic [COORD_W-1:0] coord,
   input  logic [WGT_W-1:0]   weight,
   input  logic [ACC_W-1:0]   acc,
   output logic [ACC_W-1:0]   sum
);

   logic [COORD_W+WGT_W-1:0] prod;

   // Full-width product, then widen to the accumulator for the add
   assign prod = coord * weight;
   assign sum  = acc + ACC_W'(prod);

endmodule

// File: rtl/weight_accum.sv
// weight_accum
// Accumulates sum(x*w), sum(y*w) and sum(w) over a job of NPTS points,
// one point per clock, and holds the result for a ready/valid consumer.
//   clk        : clock, rising edge
//   RESET      : asynchronous active-low reset
//   x0..x5     : point x coordinates (latched on the accepted start edge)
//   y0..y5     : point y coordinates (latched on the accepted start edge)
//   w0..w5     : point weights (latched on the accepted start edge)
//   start      : job request, only looked at in IDLE
//   busy       : high whenever the FSM is not in IDLE
//   sumxw      : sum of x*w
//   sumyw      : sum of y*w
//   sumw       : sum of w
//   zero_w     : high when sumw is zero
//   out_valid  : result available (DONE state)
//   out_ready  : consumer accepts the result
module weight_accum #(
   parameter int NPTS    = center_pkg::NPTS,
   parameter int COORD_W = center_pkg::COORD_W,
   parameter int WGT_W   = center_pkg::WGT_W
) (
   input  logic                           clk,
   input  logic                           RESET,
   input  logic [COORD_W-1:0]             x0,
   input  logic [COORD_W-1:0]             x1,
   input  logic [COORD_W-1:0]             x2,
   input  logic [COORD_W-1:0]             x3,
   input  logic [COORD_W-1:0]             x4,
   input  logic [COORD_W-1:0]             x5,
   input  logic [COORD_W-1:0]             y0,
   input  logic [COORD_W-1:0]             y1,
   input  logic [COORD_W-1:0]             y2,
   input  logic [COORD_W-1:0]             y3,
   input  logic [COORD_W-1:0]             y4,
   input  logic [COORD_W-1:0]             y5,
   input  logic [WGT_W-1:0]               w0,
   input  logic [WGT_W-1:0]               w1,
   input  logic [WGT_W-1:0]               w2,
   input  logic [WGT_W-1:0]               w3,
   input  logic [WGT_W-1:0]               w4,
   input  logic [WGT_W-1:0]               w5,
   input  logic                           start,
   output logic                           busy,
   output logic [center_pkg::SUMXY_W-1:0] sumxw,
   output logic [center_pkg::SUMXY_W-1:0] sumyw,
   output logic [center_pkg::SUMW_W-1:0]  sumw,
   output logic                           zero_w,
   output logic                           out_valid,
   input  logic                           out_ready
);

   import center_pkg::*;

   localparam int IDX_W = $clog2(NPTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

   state_t state;
   state_t state_next;

   logic [IDX_W-1:0]   idx;
   logic [COORD_W-1:0] x_in  [NPTS];
   logic [COORD_W-1:0] y_in  [NPTS];
   logic [WGT_W-1:0]   w_in  [NPTS];
   logic [COORD_W-1:0] x_lat [NPTS];
   logic [COORD_W-1:0] y_lat [NPTS];
   logic [WGT_W-1:0]   w_lat [NPTS];

   logic [COORD_W-1:0] cur_x;
   logic [COORD_W-1:0] cur_y;
   logic [WGT_W-1:0]   cur_w;
   logic [SUMXY_W-1:0] next_sumxw;
   logic [SUMXY_W-1:0] next_sumyw;

   assign x_in = '{x0, x1, x2, x3, x4, x5};
   assign y_in = '{y0, y1, y2, y3, y4, y5};
   assign w_in = '{w0, w1, w2, w3, w4, w5};

   // Point-select mux: the operands of the point being accumulated this cycle
   // always come from the latched copy, so the live inputs are free to change
   // once a job has been accepted.
   assign cur_x = x_lat[idx];
   assign cur_y = y_lat[idx];
   assign cur_w = w_lat[idx];

   point_mac #(
      .COORD_W (COORD_W),
      .WGT_W   (WGT_W),
      .ACC_W   (SUMXY_W)
   ) u_mac_x (
      .coord  (cur_x),
      .weight (cur_w),
      .acc    (sumxw),
      .sum    (next_sumxw)
   );

   point_mac #(
      .COORD_W (COORD_W),
      .WGT_W   (WGT_W),
      .ACC_W   (SUMXY_W)
   ) u_mac_y (
      .coord  (cur_y),
      .weight (cur_w),
      .acc    (sumyw),
      .sum    (next_sumyw)
   );

   // State register; reset drops straight back to IDLE and abandons any job
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start is only honoured in IDLE, ACC runs exactly NPTS
   // edges, and DONE waits for the consumer's handshake
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ACC;
            end
         end
         ACC: begin
            if (idx == LAST_IDX) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand latch and accumulators. The accepted start edge snapshots all
   // points and clears the sums; each ACC edge folds in one point. Outside
   // those two cases everything holds, which keeps the result stable through
   // DONE and on into IDLE until the next job clears it. idx wraps back to 0
   // on the last point so it never selects past the operand array.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         idx   <= '0;
         sumxw <= '0;
         sumyw <= '0;
         sumw  <= '0;
         for (int i = 0; i < NPTS; i++) begin
            x_lat[i] <= '0;
            y_lat[i] <= '0;
            w_lat[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx   <= '0;
                  sumxw <= '0;
                  sumyw <= '0;
                  sumw  <= '0;
                  for (int i = 0; i < NPTS; i++) begin
                     x_lat[i] <= x_in[i];
                     y_lat[i] <= y_in[i];
                     w_lat[i] <= w_in[i];
                  end
               end
            end
            ACC: begin
               sumxw <= next_sumxw;
               sumyw <= next_sumyw;
               sumw  <= sumw + SUMW_W'(cur_w);
               idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign zero_w    = (sumw == '0);

endmodule

// File: tb/tb_weight_accum.sv
// tb_weight_accum
// Self-checking bench for weight_accum. A job-level model tracks where the
// block must be (idle, n-th accumulate edge, done) and what the result must be,
// computed directly as plain sums over the points captured at the start edge.
// A negedge process compares the DUT against that model every cycle; directed
// jobs additionally check hand-computed literal results and exact latency.
module tb_weight_accum;

   logic       clk;
   logic       RESET;
   logic [7:0] xin [6];
   logic [7:0] yin [6];
   logic [3:0] win [6];
   logic       start;
   logic       out_ready;
   logic       busy;
   logic [14:0] sumxw;
   logic [14:0] sumyw;
   logic [6:0]  sumw;
   logic        zero_w;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   weight_accum dut (
      .clk       (clk),
      .RESET     (RESET),
      .x0        (xin[0]),
      .x1        (xin[1]),
      .x2        (xin[2]),
      .x3        (xin[3]),
      .x4        (xin[4]),
      .x5        (xin[5]),
      .y0        (yin[0]),
      .y1        (yin[1]),
      .y2        (yin[2]),
      .y3        (yin[3]),
      .y4        (yin[4]),
      .y5        (yin[5]),
      .w0        (win[0]),
      .w1        (win[1]),
      .w2        (win[2]),
      .w3        (win[3]),
      .w4        (win[4]),
      .w5        (win[5]),
      .start     (start),
      .busy      (busy),
      .sumxw     (sumxw),
      .sumyw     (sumyw),
      .sumw      (sumw),
      .zero_w    (zero_w),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Job model: phase 0 = idle, 1..6 = accumulate edges still to come, 7 = done.
   // The result is the plain arithmetic sum over the captured points and
   // becomes visible when the sixth accumulate edge has happened.
   int mPhase = 0;
   int jobX, jobY, jobW;
   int heldX = 0, heldY = 0, heldW = 0;

   always @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         mPhase = 0;
         heldX  = 0;
         heldY  = 0;
         heldW  = 0;
      end else if (mPhase == 0) begin
         if (start) begin
            jobX = 0;
            jobY = 0;
            jobW = 0;
            for (int i = 0; i < 6; i++) begin
               jobX += int'(xin[i]) * int'(win[i]);
               jobY += int'(yin[i]) * int'(win[i]);
               jobW += int'(win[i]);
            end
            mPhase = 1;
         end
      end else if (mPhase < 6) begin
         mPhase++;
      end else if (mPhase == 6) begin
         mPhase = 7;
         heldX  = jobX;
         heldY  = jobY;
         heldW  = jobW;
      end else if (out_ready) begin
         mPhase = 0;
      end
   end

   // Every-cycle comparison against the model; the sums are only meaningful
   // while idle or done (mid-job they are partial)
   always @(negedge clk) begin
      checkOutput("cyc_busy", busy, (mPhase != 0));
      checkOutput("cyc_out_valid", out_valid, (mPhase == 7));
      if (mPhase == 0 || mPhase == 7) begin
         checkOutput("cyc_sumxw", sumxw, heldX);
         checkOutput("cyc_sumyw", sumyw, heldY);
         checkOutput("cyc_sumw", sumw, heldW);
         checkOutput("cyc_zero_w", zero_w, (heldW == 0));
      end
   end

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Fill the point inputs for one of the directed job kinds
   task automatic loadJob(input int kind);
      for (int i = 0; i < 6; i++) begin
         case (kind)
            1: begin xin[i] = 8'd10; yin[i] = 8'd20; win[i] = 4'd1; end
            2: begin xin[i] = 8'd255; yin[i] = 8'd255; win[i] = 4'd15; end
            3: begin xin[i] = 8'(10 * i); yin[i] = 8'd255; win[i] = 4'(i + 1); end
            default: begin xin[i] = 8'(77 + i); yin[i] = 8'(99 - i); win[i] = 4'd0; end
         endcase
      end
   endtask

   // Present a job and pulse start across exactly one rising edge
   task automatic applyStimulus(input int kind);
      loadJob(kind);
      start = 1'b1;
      stepEdge();
      start = 1'b0;
   endtask

   // Run a job to DONE, checking exact latency and the hand-computed result
   task automatic runJob(input int kind, input bit perturb, input string tag);
      int ex, ey, ew;
      case (kind)
         1: begin ex = 60;    ey = 120;   ew = 6;  end
         2: begin ex = 22950; ey = 22950; ew = 90; end
         3: begin ex = 700;   ey = 5355;  ew = 21; end
         default: begin ex = 0; ey = 0; ew = 0; end
      endcase
      applyStimulus(kind);
      for (int i = 0; i < 5; i++) begin
         stepEdge();
         if (perturb && i == 1) begin
            for (int j = 0; j < 6; j++) begin
               xin[j] = 8'($urandom_range(0, 255));
               yin[j] = 8'($urandom_range(0, 255));
               win[j] = 4'($urandom_range(0, 15));
            end
         end
      end
      checkOutput({tag, "_valid_early"}, out_valid, 0);
      stepEdge();
      checkOutput({tag, "_valid"}, out_valid, 1);
      checkOutput({tag, "_sumxw"}, sumxw, ex);
      checkOutput({tag, "_sumyw"}, sumyw, ey);
      checkOutput({tag, "_sumw"}, sumw, ew);
      checkOutput({tag, "_zero_w"}, zero_w, (ew == 0));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      stepEdge();
      out_ready = 1'b0;
      checkOutput({tag, "_idle_busy"}, busy, 0);
      checkOutput({tag, "_idle_valid"}, out_valid, 0);
   endtask

   initial begin
      RESET     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      loadJob(1);
      #2;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_sumxw", sumxw, 0);
      checkOutput("rst_sumw", sumw, 0);
      checkOutput("rst_zero_w", zero_w, 1);
      @(posedge clk);
      #1;
      RESET = 1'b1;
      stepEdge();

      runJob(1, 1'b0, "uniform");
      handshake("uniform");
      checkOutput("uniform_held_sumxw", sumxw, 60);
      stepEdge();

      runJob(2, 1'b0, "maxjob");
      handshake("maxjob");

      runJob(3, 1'b1, "ramp");
      handshake("ramp");

      runJob(4, 1'b0, "zerow");
      handshake("zerow");

      // Hold result with out_ready low while start toggles
      runJob(1, 1'b0, "hold");
      for (int i = 0; i < 5; i++) begin
         start = ~start;
         stepEdge();
         checkOutput("hold_valid", out_valid, 1);
         checkOutput("hold_sumyw", sumyw, 120);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      stepEdge();
      start     = 1'b0;
      out_ready = 1'b0;
      checkOutput("hold_release_busy", busy, 0);
      checkOutput("hold_release_valid", out_valid, 0);
      stepEdge();
      checkOutput("hold_no_restart", busy, 0);

      // Reset in the middle of a job, asynchronously between edges
      applyStimulus(3);
      stepEdge();
      stepEdge();
      stepEdge();
      #1;
      RESET = 1'b0;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_valid", out_valid, 0);
      checkOutput("midrst_sumxw", sumxw, 0);
      checkOutput("midrst_sumw", sumw, 0);
      checkOutput("midrst_zero_w", zero_w, 1);
      @(posedge clk);
      #1;
      RESET = 1'b1;
      stepEdge();
      checkOutput("midrst_idle_valid", out_valid, 0);
      runJob(1, 1'b0, "postrst");
      handshake("postrst");

      stepEdge();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/weight_accum.md
WEIGHT_ACCUM -- requirements
Module: weight_accum

Interface
REQ-001 The block SHALL have parameter NPTS, default 6, meaning number of points accumulated per job.
REQ-002 The block SHALL have parameter COORD_W, default 8, meaning coordinate width.
REQ-003 The block SHALL have parameter WGT_W, default 4, meaning weight width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports x0..x5 and y0..y5, inputs, 8 bits each: point coordinates.
REQ-007 The block SHALL have ports w0..w5, inputs, 4 bits each: point weights.
REQ-008 The block SHALL have port start, input, 1 bit: job request, sampled in IDLE only.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have ports sumxw and sumyw, outputs, 15 bits each: sum of x*w and sum of y*w.
REQ-011 The block SHALL have port sumw, output, 7 bits: sum of w.
REQ-012 The block SHALL have port zero_w, output, 1 bit: high when the result sumw equals 0.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer (centroid stage) accepts the result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-016 In IDLE, a rising edge with start=1 SHALL, on that edge, latch all x/y/w inputs into internal registers, clear all accumulators, set idx=0 and enter ACC.
REQ-017 In ACC, each edge SHALL add x[idx]*w[idx], y[idx]*w[idx] and w[idx] from the latched operands, then increment idx; the edge that adds idx=5 SHALL enter DONE.
REQ-018 The latency SHALL be exactly: start accepted at edge k, out_valid high after edge k+6.
REQ-019 Each product SHALL be 12 bits unsigned and the accumulators SHALL be 15/15/7 bits; the maximum job (255*15*6=22950, 90) SHALL NOT overflow.
REQ-020 In DONE, out_valid SHALL be 1 and sumxw/sumyw/sumw/zero_w SHALL stay stable until an edge with out_ready=1.
REQ-021 An edge in DONE with out_ready=1 SHALL clear out_valid and return to IDLE.
REQ-022 Result outputs SHALL hold their values in IDLE until the next accepted start.
REQ-023 start SHALL be ignored in ACC and in DONE, including on the handshake edge; a new job needs start asserted in IDLE.
REQ-024 Input changes after the start edge SHALL NOT affect the current job.
REQ-025 zero_w SHALL be computed from the final sumw and be valid whenever out_valid=1.

Reset
REQ-026 RESET=0 SHALL immediately force state IDLE, idx=0, busy=0, out_valid=0, sumxw=0, sumyw=0, sumw=0 and zero_w=1, regardless of the clock.
REQ-027 Reset mid-job SHALL abandon the job without producing out_valid, and a start after reset release SHALL behave as a fresh job.

Structure
REQ-028 Shared package center_pkg SHALL hold NPTS, COORD_W, WGT_W, SUMXY_W=15, SUMW_W=7 and the state enum {IDLE, ACC, DONE}.
REQ-029 One sub-module point_mac SHALL take (coord, weight, acc) and produce acc+coord*weight; it SHALL be instantiated twice (x and y).
REQ-030 The point-select mux and the FSM SHALL stay in weight_accum.

Verification
REQ-031 All x=10, y=20, w=1, start pulse -> after 6 edges: out_valid=1, sumxw=60, sumyw=120, sumw=6, zero_w=0.
REQ-032 All x=y=255, w=15 -> sumxw=22950, sumyw=22950, sumw=90, no wrap.
REQ-033 x_i=10*i, y=255, w_i=i+1 -> sumxw=700, sumyw=5355, sumw=21; inputs changed mid-job -> same result.
REQ-034 All w=0 -> sums all 0, zero_w=1, out_valid=1.
REQ-035 out_ready low for 5 cycles with start toggling -> out_valid and outputs stable, no new job; out_ready=1 -> IDLE next edge.
REQ-036 RESET low after 3 ACC edges -> outputs 0, busy=0, no out_valid; a subsequent job of case REQ-031 -> correct result.
